// File: rtl/measure_rx_pkg.sv
// measure_rx_pkg: shared constants, state encoding and bundles
// for the XGMII measurement-frame receiver.
package measure_rx_pkg;

  localparam logic [39:0] MAGIC_CODE = 40'hA5C3_5A3C_E1;

  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERR   = 8'hFE;
  localparam logic [7:0] XG_IDLE  = 8'h07;

  localparam logic [7:0] ETH_IPV4_HI = 8'h08;
  localparam logic [7:0] ETH_IPV4_LO = 8'h00;
  localparam logic [7:0] IPV4_VIHL   = 8'h45;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef struct packed {
    logic [31:0] len;
    logic [23:0] lat;
    logic [31:0] ip;
  } frame_t;

  function automatic logic [7:0] xg_lane(
    input logic [63:0] d,
    input int          k
  );
    return d[8*k +: 8];
  endfunction

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/measure_rx_if.sv
// measure_rx_if: XGMII receive bus (64-bit data, 8 control flags).
// master drives the bus, slave (the receiver) samples it.
interface measure_rx_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/measure_rx_window.sv
// measure_rx_window: one-second window counter, saturating frame/byte
// accumulators and registered stats (pps, throughput, latency, ip).
module measure_rx_window
  import measure_rx_pkg::*;
#(
  parameter int unsigned SEC_CYCLES = 156250000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        done_i,
  input  frame_t      frame_i,
  output logic [31:0] pps_o,
  output logic [31:0] tput_o,
  output logic [23:0] lat_o,
  output logic [31:0] ip_o
);

  localparam logic [31:0] RELOAD = 32'(SEC_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] accp_q, accp_d;
  logic [31:0] accb_q, accb_d;
  logic [31:0] pps_q, pps_d;
  logic [31:0] tput_q, tput_d;
  logic [23:0] lat_q, lat_d;
  logic [31:0] ip_q, ip_d;
  logic        tick;
  logic [31:0] accp_b, accb_b;

  assign tick = (cnt_q == 32'd0);

  always_comb begin
    cnt_d  = tick ? RELOAD : cnt_q - 32'd1;
    pps_d  = tick ? accp_q : pps_q;
    tput_d = tick ? accb_q : tput_q;
    // a frame finishing on the tick belongs to the new window
    accp_b = tick ? 32'd0 : accp_q;
    accb_b = tick ? 32'd0 : accb_q;
    accp_d = accp_b;
    accb_d = accb_b;
    lat_d  = lat_q;
    ip_d   = ip_q;
    if (done_i) begin
      accp_d = sat_add(accp_b, 32'd1);
      accb_d = sat_add(accb_b, frame_i.len);
      lat_d  = frame_i.lat;
      ip_d   = frame_i.ip;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= RELOAD;
      accp_q <= '0;
      accb_q <= '0;
      pps_q  <= '0;
      tput_q <= '0;
      lat_q  <= '0;
      ip_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      accp_q <= accp_d;
      accb_q <= accb_d;
      pps_q  <= pps_d;
      tput_q <= tput_d;
      lat_q  <= lat_d;
      ip_q   <= ip_d;
    end
  end

  assign pps_o  = pps_q;
  assign tput_o = tput_q;
  assign lat_o  = lat_q;
  assign ip_o   = ip_q;

endmodule

// File: rtl/measure_rx.sv
// measure_rx: parses XGMII measurement frames (IPv4/UDP + magic),
// ports: sys_clk, sys_rst_n, xgmii bus, global_counter, rx_* stats.
module measure_rx
  import measure_rx_pkg::*;
#(
  parameter int unsigned SEC_CYCLES = 156250000,
  parameter logic [39:0] MAGIC_CODE = measure_rx_pkg::MAGIC_CODE
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  measure_rx_if.slave xgmii,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip
);

  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic [1:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d, idx_inc, idx_m1;
  logic [31:0] ip_q, ip_d;
  logic [23:0] lat_q, lat_d;
  logic        term, ctl_err, hdr_ok;
  logic        idle_w, start_w, done;
  logic [3:0]  tlane;
  logic [7:0]  pre_mask;
  frame_t      frame;

  assign rxd = xgmii.xgmii_rxd;
  assign rxc = xgmii.xgmii_rxc;

  // lowest lane carrying a terminate; 8 when none
  always_comb begin
    term  = 1'b0;
    tlane = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (rxc[k] && xg_lane(rxd, k) == XG_TERM) begin
        term  = 1'b1;
        tlane = 4'(k);
      end
    end
  end

  // any control character ahead of the terminate aborts the frame
  assign pre_mask = (8'd1 << tlane) - 8'd1;
  assign ctl_err  = |(rxc & pre_mask);

  assign start_w = (rxc == 8'h01) && (rxd[7:0] == XG_START);
  assign idle_w  = (rxc == 8'hFF) && (rxd == {8{XG_IDLE}});

  always_comb begin
    hdr_ok = 1'b1;
    unique case (1'b1)
      idx_q == 16'd2:
        hdr_ok = xg_lane(rxd, 4) == ETH_IPV4_HI &&
                 xg_lane(rxd, 5) == ETH_IPV4_LO &&
                 xg_lane(rxd, 6) == IPV4_VIHL;
      idx_q == 16'd3:
        hdr_ok = xg_lane(rxd, 7) == IP_PROTO_UDP;
      idx_q == 16'd6:
        hdr_ok = {xg_lane(rxd, 2), xg_lane(rxd, 3),
                  xg_lane(rxd, 4), xg_lane(rxd, 5),
                  xg_lane(rxd, 6)} == MAGIC_CODE;
      default: hdr_ok = 1'b1;
    endcase
  end

  assign idx_inc = (&idx_q) ? idx_q : idx_q + 16'd1;
  assign idx_m1  = idx_q - 16'd1;

  assign done = (state_q == ST_BODY) && term &&
                !ctl_err && (idx_q >= 16'd8);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ip_d    = ip_q;
    lat_d   = lat_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (start_w) begin
          state_d = ST_HDR;
          idx_d   = 16'd1;
        end
      end
      state_q == ST_HDR: begin
        idx_d = idx_inc;
        if (idx_q == 16'd4)
          ip_d = {xg_lane(rxd, 2), xg_lane(rxd, 3),
                  xg_lane(rxd, 4), xg_lane(rxd, 5)};
        if (idx_q == 16'd7) begin
          lat_d   = global_counter[23:0] -
                    {xg_lane(rxd, 0), xg_lane(rxd, 1),
                     xg_lane(rxd, 2)};
          state_d = ST_BODY;
        end
        if (!hdr_ok || ctl_err)
          state_d = ST_DROP;
      end
      state_q == ST_BODY: begin
        idx_d = idx_inc;
        if (ctl_err)
          state_d = ST_DROP;
      end
      default: begin
        idx_d = idx_inc;
        if (idle_w)
          state_d = ST_IDLE;
      end
    endcase
    if (state_q != ST_IDLE && term)
      state_d = ST_IDLE;
    if (state_d == ST_IDLE)
      idx_d = 16'd0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ip_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ip_q    <= ip_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    frame.len = {13'd0, idx_m1, 3'd0} + {28'd0, tlane};
    frame.lat = lat_q;
    frame.ip  = ip_q;
  end

  measure_rx_window #(
    .SEC_CYCLES(SEC_CYCLES)
  ) u_window (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .done_i (done),
    .frame_i(frame),
    .pps_o  (rx_pps),
    .tput_o (rx_throughput),
    .lat_o  (rx_latency),
    .ip_o   (rx_ipv4_ip)
  );

endmodule

// File: tb/tb_measure_rx.sv
// tb_measure_rx: randomized frames against a byte-level frame model,
// scoreboard of completed frames checked by a per-cycle monitor.
module tb_measure_rx;
  import measure_rx_pkg::*;

  localparam int SEC = 100;
  localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cyc = '0;
  logic [31:0] gc_off = '0;
  logic [31:0] gc;
  logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip;
  logic [23:0] rx_latency;
  int          edge_n;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    int          edge_no;
    logic [23:0] lat;
    logic [31:0] ip;
    int          len;
  } ev_t;
  ev_t evq[$];

  assign gc = cyc + gc_off;

  measure_rx_if xif ();

  measure_rx #(
    .SEC_CYCLES(SEC)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .xgmii         (xif.slave),
    .global_counter(gc),
    .rx_pps        (rx_pps),
    .rx_throughput (rx_throughput),
    .rx_latency    (rx_latency),
    .rx_ipv4_ip    (rx_ipv4_ip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // number of clock edges seen since reset was released
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else edge_n <= edge_n + 1;

  task automatic check(input string nm,
                       input logic [119:0] act,
                       input logic [119:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: reference model of windows and latest-frame stats
  initial begin : monitor
    logic [31:0] m_pps, m_tp, m_ip, a_p, a_b;
    logic [23:0] m_lat;
    ev_t ev;
    m_pps = 0; m_tp = 0; m_ip = 0; m_lat = 0;
    a_p = 0; a_b = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_pps = 0; m_tp = 0; m_ip = 0; m_lat = 0;
        a_p = 0; a_b = 0;
        evq.delete();
        check("reset_outputs",
              {rx_pps, rx_throughput, rx_latency, rx_ipv4_ip},
              120'd0);
      end else begin
        if (edge_n % SEC == 0) begin
          m_pps = a_p;
          m_tp  = a_b;
          a_p = 0;
          a_b = 0;
        end
        while (evq.size() > 0 && evq[0].edge_no <= edge_n) begin
          ev = evq.pop_front();
          m_lat = ev.lat;
          m_ip  = ev.ip;
          a_p = (a_p == 32'hFFFF_FFFF) ? a_p : a_p + 1;
          a_b = ({1'b0, a_b} + 33'(ev.len) > 33'h0_FFFF_FFFF) ?
                32'hFFFF_FFFF : a_b + 32'(ev.len);
        end
        check($sformatf("outputs@%0d", edge_n),
              {rx_pps, rx_throughput, rx_latency, rx_ipv4_ip},
              {m_pps, m_tp, m_lat, m_ip});
      end
    end
  end

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    xif.xgmii_rxd = d;
    xif.xgmii_rxc = c;
  endtask

  // kind: 0 good, 1 bad magic, 2 FE at byte 67, 3 reset at idx4, 4 TCP
  task automatic send_frame(input int len, input logic [31:0] ip,
                            input logic [23:0] lat, input int kind,
                            input bit wrap, input int gap);
    logic [7:0]  fb [256];
    logic [39:0] mg;
    logic [63:0] d;
    logic [7:0]  c;
    logic [31:0] now;
    logic [23:0] ts;
    int tw, pos;
    mg = MAGIC_CODE;
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    fb[12] = 8'h08;
    fb[13] = 8'h00;
    fb[14] = 8'h45;
    fb[23] = (kind == 4) ? 8'h06 : 8'h11;
    {fb[26], fb[27], fb[28], fb[29]} = ip;
    for (int k = 0; k < 5; k++) fb[42+k] = mg[39-8*k -: 8];
    if (kind == 1) fb[46] = ~mg[7:0];
    tw = 1 + len / 8;
    for (int w = 0; w <= tw; w++) begin
      @(negedge clk);
      if (kind == 3 && w == 4) begin
        rst_n = 1'b0;
        drive(IDLE_W, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (w == 7) begin
        now = gc;
        if (wrap) begin
          gc_off = gc_off + (32'h0000_0010 - gc);
          now = 32'h0000_0010;
        end
        ts = now[23:0] - lat;
        {fb[48], fb[49], fb[50]} = ts;
      end
      if (w == 0) begin
        d = 64'hD555_5555_5555_55FB;
        c = 8'h01;
      end else begin
        for (int l = 0; l < 8; l++) begin
          pos = 8 * (w - 1) + l;
          if (kind == 2 && pos == 67) begin
            d[8*l +: 8] = 8'hFE; c[l] = 1'b1;
          end else if (pos < len) begin
            d[8*l +: 8] = fb[pos]; c[l] = 1'b0;
          end else if (pos == len) begin
            d[8*l +: 8] = 8'hFD; c[l] = 1'b1;
          end else begin
            d[8*l +: 8] = 8'h07; c[l] = 1'b1;
          end
        end
      end
      if (w == tw && kind == 0 && len >= 56)
        evq.push_back('{edge_n + 1, lat, ip, len});
      drive(d, c);
    end
    repeat (gap) begin
      @(negedge clk);
      drive(IDLE_W, 8'hFF);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((edge_n % SEC != 0 || edge_n == 0) && k < 3 * SEC);
    if (k >= 3 * SEC) check("tick_timeout", 120'(k), 120'd0);
  endtask

  initial begin : stim
    int k, kd, kind, len;
    drive(IDLE_W, 8'hFF);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      send_frame(60, 32'hC0A8_0001 + 32'(i), 24'd256, 0, 1'b0, 2);
      check("lat256", 120'(rx_latency), 120'd256);
    end
    wait_tick();
    check("pps3", 120'(rx_pps), 120'd3);
    check("tput180", 120'(rx_throughput), 120'd180);

    send_frame(64, 32'h0A00_0001, 24'd32, 0, 1'b1, 2);
    check("lat_wrap", 120'(rx_latency), 120'd32);
    check("ip_wrap", 120'(rx_ipv4_ip), 120'h0A00_0001);

    send_frame(64, 32'h0A00_00FF, 24'd77, 1, 1'b0, 2);
    check("badmagic_lat", 120'(rx_latency), 120'd32);
    check("badmagic_ip", 120'(rx_ipv4_ip), 120'h0A00_0001);

    send_frame(96, 32'h0D00_0001, 24'd99, 2, 1'b0, 2);
    send_frame(35, 32'h0D00_0002, 24'd98, 0, 1'b0, 2);
    check("abort_runt_lat", 120'(rx_latency), 120'd32);
    send_frame(72, 32'h0B0B_0B0B, 24'd500, 0, 1'b0, 2);
    check("after_abort_lat", 120'(rx_latency), 120'd500);
    check("after_abort_ip", 120'(rx_ipv4_ip), 120'h0B0B_0B0B);

    // terminate of a 60-byte frame lands exactly on a tick edge
    k = 0;
    while ((edge_n + 10) % SEC != 0 && k < 3 * SEC) begin
      @(negedge clk);
      k++;
    end
    send_frame(60, 32'h0E0E_0E0E, 24'd700, 0, 1'b0, 2);
    wait_tick();
    check("tick_pps1", 120'(rx_pps), 120'd1);
    check("tick_tput60", 120'(rx_throughput), 120'd60);

    send_frame(80, 32'hDEAD_0001, 24'd111, 3, 1'b0, 0);
    repeat (2) @(negedge clk);
    send_frame(64, 32'h0C0C_0C0C, 24'd1234, 0, 1'b0, 2);
    check("post_rst_lat", 120'(rx_latency), 120'd1234);
    check("post_rst_ip", 120'(rx_ipv4_ip), 120'h0C0C_0C0C);
    wait_tick();
    check("post_rst_pps", 120'(rx_pps), 120'd1);
    check("post_rst_tput", 120'(rx_throughput), 120'd64);

    for (int i = 0; i < 40; i++) begin
      kd = $urandom_range(0, 9);
      kind = (kd < 6) ? 0 : (kd == 6) ? 1 : (kd == 7) ? 2 :
             (kd == 8) ? 4 : 0;
      len = $urandom_range(56, 160);
      if (kd == 9) len = $urandom_range(9, 55);
      if (kind == 2 && len < 80) len = 80;
      send_frame(len, $urandom, 24'($urandom), kind, 1'b0,
                 $urandom_range(1, 4));
    end
    wait_tick();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
